// File: rtl/ctrl_pkg.sv
// Shared state, opcode, ALU and select definitions for the multicycle control unit.
// CTRL_RV32M_EN (used by ctrl_decode) adds the RV32M multiply encodings.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_SLL    = 4'b0010;
    localparam logic [3:0] ALU_SLT    = 4'b0011;
    localparam logic [3:0] ALU_SLTU   = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_AND    = 4'b1001;
    localparam logic [3:0] ALU_LUI    = 4'b1010;
    localparam logic [3:0] ALU_MUL    = 4'b1011;
    localparam logic [3:0] ALU_MULH   = 4'b1100;
    localparam logic [3:0] ALU_MULHSU = 4'b1101;
    localparam logic [3:0] ALU_MULHU  = 4'b1110;
    localparam logic [3:0] ALU_INV    = 4'b1111;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    localparam logic [1:0] OPA_RS1  = 2'b00;
    localparam logic [1:0] OPA_PC   = 2'b01;
    localparam logic [1:0] OPA_ZERO = 2'b10;

    // Sequencing class: decides which states follow EXEC.
    typedef enum logic [2:0] {
        CLS_WB     = 3'd0,
        CLS_JUMP   = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } iclass_t;

    typedef struct packed {
        logic       legal;
        iclass_t    cls;
        logic [1:0] wb_sel;
        logic [1:0] opa_sel;
        logic       opb_sel;
        logic [3:0] alu_op;
    } dec_t;

    localparam dec_t DEC_RESET = '{
        legal:   1'b0,
        cls:     CLS_WB,
        wb_sel:  WB_ALU,
        opa_sel: OPA_RS1,
        opb_sel: 1'b0,
        alu_op:  ALU_INV
    };

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I instruction decoder: legality plus all static datapath controls.
// CTRL_RV32M_EN makes funct7 0000001 / funct3 000..011 R-type encodings legal.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = i_instr[6:0];
    assign funct3        = i_instr[14:12];
    assign funct7        = i_instr[31:25];
    assign unused_fields = ^{i_instr[24:15], i_instr[11:7]};

    always_comb begin
        o_dec = DEC_RESET;
        case (opcode)
            OPC_RTYPE: begin
                o_dec.cls     = CLS_WB;
                o_dec.opb_sel = 1'b0;
                if (funct7 == 7'b0000000) begin
                    o_dec.legal  = 1'b1;
                    o_dec.alu_op = alu_from_f3(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 &&
                             (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    o_dec.legal  = 1'b1;
                    o_dec.alu_op = alu_from_f3(funct3, 1'b1);
                end
`ifdef CTRL_RV32M_EN
                else if (funct7 == 7'b0000001 && !funct3[2]) begin
                    o_dec.legal  = 1'b1;
                    o_dec.alu_op = ALU_MUL + {2'b00, funct3[1:0]};
                end
`endif
            end
            OPC_IALU: begin
                o_dec.cls     = CLS_WB;
                o_dec.opb_sel = 1'b1;
                // Shift-immediates reuse funct7 as a qualifier; other funct3 carry immediate bits there.
                if (funct3 == 3'b001) begin
                    o_dec.legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    o_dec.legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end else begin
                    o_dec.legal = 1'b1;
                end
                if (o_dec.legal) begin
                    o_dec.alu_op = alu_from_f3(funct3, (funct3 == 3'b101) && funct7[5]);
                end
            end
            OPC_LOAD: begin
                o_dec.legal   = 1'b1;
                o_dec.cls     = CLS_LOAD;
                o_dec.wb_sel  = WB_MEM;
                o_dec.opb_sel = 1'b1;
                o_dec.alu_op  = ALU_ADD;
            end
            OPC_STORE: begin
                o_dec.legal   = 1'b1;
                o_dec.cls     = CLS_STORE;
                o_dec.opb_sel = 1'b1;
                o_dec.alu_op  = ALU_ADD;
            end
            OPC_BRANCH: begin
                o_dec.legal   = 1'b1;
                o_dec.cls     = CLS_BRANCH;
                o_dec.opb_sel = 1'b0;
                o_dec.alu_op  = ALU_SUB;
            end
            OPC_JAL: begin
                o_dec.legal   = 1'b1;
                o_dec.cls     = CLS_JUMP;
                o_dec.wb_sel  = WB_PC;
                o_dec.opa_sel = OPA_PC;
                o_dec.opb_sel = 1'b1;
                o_dec.alu_op  = ALU_ADD;
            end
            OPC_JALR: begin
                o_dec.legal   = 1'b1;
                o_dec.cls     = CLS_JUMP;
                o_dec.wb_sel  = WB_PC;
                o_dec.opa_sel = OPA_RS1;
                o_dec.opb_sel = 1'b1;
                o_dec.alu_op  = ALU_ADD;
            end
            OPC_LUI: begin
                o_dec.legal   = 1'b1;
                o_dec.cls     = CLS_WB;
                o_dec.opa_sel = OPA_ZERO;
                o_dec.opb_sel = 1'b1;
                o_dec.alu_op  = ALU_LUI;
            end
            OPC_AUIPC: begin
                o_dec.legal   = 1'b1;
                o_dec.cls     = CLS_WB;
                o_dec.opa_sel = OPA_PC;
                o_dec.opb_sel = 1'b1;
                o_dec.alu_op  = ALU_ADD;
            end
            default: o_dec = DEC_RESET;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky illegal/timeout trap.
// Decode legality follows ctrl_decode, which honours CTRL_RV32M_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned ALU_OP_W    = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [31:0]         i_instr,
    input  logic                i_imem_ack,
    input  logic                i_dmem_ack,
    input  logic                i_br_taken,
    output logic                o_imem_req,
    output logic                o_ir_wren,
    output logic                o_pc_wren,
    output logic                o_pc_sel,
    output logic                o_alur_wren,
    output logic                o_dmem_req,
    output logic                o_mem_wren,
    output logic                o_rd_wren,
    output logic [1:0]          o_wb_sel,
    output logic [1:0]          o_opa_sel,
    output logic                o_opb_sel,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic [2:0]          o_state,
    output logic                o_illegal,
    output logic                o_timeout
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state_q, state_d;
    dec_t       dec_q, dec_w;
    logic [7:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       timeout_q, timeout_d;
    logic [3:0] alu_op;

    ctrl_decode u_decode (
        .i_instr (i_instr),
        .o_dec   (dec_w)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_FETCH;
            dec_q     <= DEC_RESET;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            if (state_q == ST_DECODE) begin
                dec_q <= dec_w;
            end
        end
    end

    // The counter only survives while waiting in FETCH/MEM, so every entry sees it at zero.
    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_FETCH: begin
                if (i_imem_ack) begin
                    state_d = ST_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_DECODE: begin
                if (!dec_w.legal) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (dec_q.cls)
                    CLS_BRANCH:          state_d = ST_FETCH;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (i_dmem_ack) begin
                    state_d = (dec_q.cls == CLS_STORE) ? ST_FETCH : ST_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Reset gates outputs combinationally so nothing leaks while i_reset is high.
    always_comb begin
        o_imem_req  = 1'b0;
        o_ir_wren   = 1'b0;
        o_pc_wren   = 1'b0;
        o_pc_sel    = 1'b0;
        o_alur_wren = 1'b0;
        o_dmem_req  = 1'b0;
        o_mem_wren  = 1'b0;
        o_rd_wren   = 1'b0;
        o_wb_sel    = WB_ALU;
        o_opa_sel   = OPA_RS1;
        o_opb_sel   = 1'b0;
        alu_op      = ALU_INV;
        o_state     = 3'b000;
        o_illegal   = 1'b0;
        o_timeout   = 1'b0;
        if (!i_reset) begin
            o_state   = state_q;
            o_illegal = illegal_q;
            o_timeout = timeout_q;
            o_wb_sel  = dec_q.wb_sel;
            o_opa_sel = dec_q.opa_sel;
            o_opb_sel = dec_q.opb_sel;
            alu_op    = dec_q.alu_op;
            case (state_q)
                ST_FETCH: begin
                    o_imem_req = 1'b1;
                    o_ir_wren  = i_imem_ack;
                end
                ST_EXEC: begin
                    o_alur_wren = 1'b1;
                    if (dec_q.cls == CLS_BRANCH) begin
                        o_pc_wren = 1'b1;
                        o_pc_sel  = i_br_taken;
                    end
                end
                ST_MEM: begin
                    o_dmem_req = 1'b1;
                    o_mem_wren = (dec_q.cls == CLS_STORE);
                    o_pc_wren  = i_dmem_ack && (dec_q.cls == CLS_STORE);
                end
                ST_WB: begin
                    o_rd_wren = 1'b1;
                    o_pc_wren = 1'b1;
                    o_pc_sel  = (dec_q.cls == CLS_JUMP);
                end
                default: ;
            endcase
        end
    end

    assign o_alu_op = ALU_OP_W'(alu_op);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected-cycle scoreboard
// built from the instruction-level rules, directed scenarios plus random instructions.
module tb_multicycle_ctrl;

    localparam int unsigned TMO = 16;

    localparam int K_ILL = 0;
    localparam int K_WB  = 1;
    localparam int K_JMP = 2;
    localparam int K_LD  = 3;
    localparam int K_ST  = 4;
    localparam int K_BR  = 5;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0000A283;
    localparam logic [31:0] I_SW  = 32'h0020A023;
    localparam logic [31:0] I_BEQ = 32'h00208063;
    localparam logic [31:0] I_MUL = 32'h022080B3;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_instr;
    logic        i_imem_ack, i_dmem_ack, i_br_taken;
    logic        o_imem_req, o_ir_wren, o_pc_wren, o_pc_sel, o_alur_wren;
    logic        o_dmem_req, o_mem_wren, o_rd_wren, o_opb_sel;
    logic [1:0]  o_wb_sel, o_opa_sel;
    logic [3:0]  o_alu_op;
    logic [2:0]  o_state;
    logic        o_illegal, o_timeout;
    logic [21:0] all_outs;

    multicycle_ctrl #(.TIMEOUT_CYC(TMO), .ALU_OP_W(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr),
        .i_imem_ack(i_imem_ack), .i_dmem_ack(i_dmem_ack), .i_br_taken(i_br_taken),
        .o_imem_req(o_imem_req), .o_ir_wren(o_ir_wren), .o_pc_wren(o_pc_wren),
        .o_pc_sel(o_pc_sel), .o_alur_wren(o_alur_wren), .o_dmem_req(o_dmem_req),
        .o_mem_wren(o_mem_wren), .o_rd_wren(o_rd_wren), .o_wb_sel(o_wb_sel),
        .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel), .o_alu_op(o_alu_op),
        .o_state(o_state), .o_illegal(o_illegal), .o_timeout(o_timeout)
    );

    assign all_outs = {o_imem_req, o_ir_wren, o_pc_wren, o_pc_sel, o_alur_wren, o_dmem_req,
                       o_mem_wren, o_rd_wren, o_wb_sel, o_opa_sel, o_opb_sel, o_alu_op,
                       o_state, o_illegal, o_timeout};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One expected cycle: state, control strobes, flags, and the acks to drive in it.
    typedef struct {
        logic [2:0] st;
        logic [7:0] ctl;   // imem_req ir_wren pc_wren pc_sel alur_wren dmem_req mem_wren rd_wren
        logic       ill;
        logic       tmo;
        logic       ia;
        logic       da;
        logic       chk_alu;
        logic [3:0] alu;
        logic       chk_wb;
        logic [1:0] wb;
    } rec_t;

    rec_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   trap_expected;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void classify(input logic [31:0] ins, output int kind,
                                     output logic [3:0] alu, output logic [1:0] wb);
        logic [3:0] base [8] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        kind = K_ILL;
        alu  = 4'hF;
        wb   = 2'b00;
        case (op)
            7'b0110011: begin
                if (f7 == 7'h00) begin kind = K_WB; alu = base[f3]; end
                else if (f7 == 7'h20 && f3 == 3'd0) begin kind = K_WB; alu = 4'h1; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin kind = K_WB; alu = 4'h7; end
`ifdef CTRL_RV32M_EN
                else if (f7 == 7'h01 && f3 < 3'd4) begin kind = K_WB; alu = 4'hB + 4'(f3); end
`endif
            end
            7'b0010011: begin
                if ((f3 == 3'd1 && f7 == 7'h00) ||
                    (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)) ||
                    (f3 != 3'd1 && f3 != 3'd5)) begin
                    kind = K_WB;
                    alu  = (f3 == 3'd5 && f7 == 7'h20) ? 4'h7 : base[f3];
                end
            end
            7'b0000011: begin kind = K_LD;  alu = 4'h0; wb = 2'b01; end
            7'b0100011: begin kind = K_ST;  alu = 4'h0; end
            7'b1100011: begin kind = K_BR;  alu = 4'h1; end
            7'b1101111: begin kind = K_JMP; alu = 4'h0; wb = 2'b10; end
            7'b1100111: begin kind = K_JMP; alu = 4'h0; wb = 2'b10; end
            7'b0110111: begin kind = K_WB;  alu = 4'hA; end
            7'b0010111: begin kind = K_WB;  alu = 4'h0; end
            default: kind = K_ILL;
        endcase
    endfunction

    function automatic void push(input logic [2:0] st, input logic [7:0] ctl, input logic ill,
                                 input logic tmo, input logic ia, input logic da,
                                 input logic ca, input logic [3:0] alu,
                                 input logic cw, input logic [1:0] wb);
        rec_t r;
        r.st = st; r.ctl = ctl; r.ill = ill; r.tmo = tmo; r.ia = ia; r.da = da;
        r.chk_alu = ca; r.alu = alu; r.chk_wb = cw; r.wb = wb;
        exp_q.push_back(r);
    endfunction

    // dd < 0: data memory never acknowledges.
    task automatic build(input logic [31:0] ins, input int id, input int dd, input logic br);
        int         kind;
        logic [3:0] alu;
        logic [1:0] wb;
        logic [7:0] mctl;
        exp_q.delete();
        trap_expected = 1'b0;
        i_instr = ins;
        classify(ins, kind, alu, wb);
        for (int i = 0; i < id; i++) push(3'd0, 8'h80, 0, 0, 0, 0, 0, 4'h0, 0, 2'b00);
        push(3'd0, 8'hC0, 0, 0, 1, 0, 0, 4'h0, 0, 2'b00);
        push(3'd1, 8'h00, 0, 0, 0, 0, 0, 4'h0, 0, 2'b00);
        if (kind == K_ILL) begin
            push(3'd5, 8'h00, 1, 0, 0, 0, 0, 4'h0, 0, 2'b00);
            push(3'd5, 8'h00, 1, 0, 0, 0, 0, 4'h0, 0, 2'b00);
            trap_expected = 1'b1;
            return;
        end
        push(3'd2, (kind == K_BR) ? (8'h28 | (br ? 8'h10 : 8'h00)) : 8'h08,
             0, 0, 0, 0, 1, alu, 0, 2'b00);
        if (kind == K_BR) return;
        if (kind == K_LD || kind == K_ST) begin
            mctl = (kind == K_ST) ? 8'h06 : 8'h04;
            if (dd < 0) begin
                for (int i = 0; i < int'(TMO); i++) push(3'd3, mctl, 0, 0, 0, 0, 1, alu, 0, 2'b00);
                push(3'd5, 8'h00, 0, 1, 0, 0, 0, 4'h0, 0, 2'b00);
                push(3'd5, 8'h00, 0, 1, 0, 0, 0, 4'h0, 0, 2'b00);
                trap_expected = 1'b1;
                return;
            end
            for (int i = 0; i < dd; i++) push(3'd3, mctl, 0, 0, 0, 0, 1, alu, 0, 2'b00);
            push(3'd3, mctl | ((kind == K_ST) ? 8'h20 : 8'h00), 0, 0, 0, 1, 1, alu, 0, 2'b00);
            if (kind == K_ST) return;
        end
        push(3'd4, 8'h21 | ((kind == K_JMP) ? 8'h10 : 8'h00), 0, 0, 0, 0, 1, alu, 1, wb);
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic play(input int limit, input logic br);
        rec_t r;
        int   n = 0;
        while (exp_q.size() > 0 && (limit == 0 || n < limit)) begin
            r = exp_q.pop_front();
            i_imem_ack = r.ia;
            i_dmem_ack = r.da;
            i_br_taken = br;
            #3;
            check("state", 32'(o_state), 32'(r.st));
            check("ctl_flags", 32'({o_imem_req, o_ir_wren, o_pc_wren, o_pc_sel, o_alur_wren,
                                    o_dmem_req, o_mem_wren, o_rd_wren, o_illegal, o_timeout}),
                  32'({r.ctl, r.ill, r.tmo}));
            if (r.chk_alu) check("alu_op", 32'(o_alu_op), 32'(r.alu));
            if (r.chk_wb)  check("wb_sel", 32'(o_wb_sel), 32'(r.wb));
            @(posedge i_clk);
            #1;
            n++;
        end
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
        i_br_taken = 1'b0;
        i_reset    = 1'b1;
        #1;
        check("reset_outputs", 32'(all_outs), 32'h1E0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    task automatic run_one(input logic [31:0] ins, input int id, input int dd, input logic br);
        build(ins, id, dd, br);
        play(0, br);
        if (trap_expected) do_reset();
    endtask

    initial begin
        logic [31:0] ins;
        int          sel;
        int          f7sel;
        i_reset    = 1'b0;
        i_instr    = '0;
        i_imem_ack = 1'b0;
        i_dmem_ack = 1'b0;
        i_br_taken = 1'b0;
        #2;
        do_reset();

        run_one(I_ADD, 0, 0, 1'b0);
        run_one(I_LW, 0, 3, 1'b0);
        run_one(I_BEQ, 1, 0, 1'b1);
        run_one(I_BEQ, 0, 0, 1'b0);
        run_one(I_LW, int'(TMO) - 1, int'(TMO) - 1, 1'b0);
        run_one(I_SW, 2, 1, 1'b0);
        run_one(I_MUL, 0, 0, 1'b0);

        for (int k = 0; k < 60; k++) begin
            ins   = $urandom();
            sel   = int'($urandom_range(0, 9));
            f7sel = int'($urandom_range(0, 3));
            case (sel)
                0, 1: ins[6:0] = 7'b0110011;
                2, 3: ins[6:0] = 7'b0010011;
                4:    ins[6:0] = 7'b0000011;
                5:    ins[6:0] = 7'b0100011;
                6:    ins[6:0] = 7'b1100011;
                7:    ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'b1101111 : 7'b1100111;
                8:    ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'b0110111 : 7'b0010111;
                default: ;
            endcase
            if (f7sel == 0) ins[31:25] = 7'h00;
            else if (f7sel == 1) ins[31:25] = 7'h20;
            else if (f7sel == 2) ins[31:25] = 7'h01;
            run_one(ins, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)));
        end

        run_one(I_SW, 0, -1, 1'b0);
        run_one(I_ADD, 0, 0, 1'b0);

        build(I_SW, 0, 3, 1'b0);
        play(5, 1'b0);
        i_reset = 1'b1;
        #1;
        check("reset_mid_mem", 32'(all_outs), 32'h1E0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        #2;
        check("imem_req_after_reset", 32'(o_imem_req), 32'd1);
        check("state_after_reset", 32'(o_state), 32'd0);
        exp_q.delete();
        @(posedge i_clk);
        #1;
        do_reset();
        run_one(I_ADD, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
